mem_bus_arbiter: RTL and testbench

- Shares one byte-wide synchronous RAM between two requesters on the cpu bus protocol: port 0 is the cpu, port 1 is the program loader/debug master.
- Splits each 1–4-byte request into byte accesses, little-endian.
- Assembles read data and answers with a one-cycle ready pulse on the requester's own dataInReady/dataOutReady.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared cpu-bus definitions: arbiter state encoding, byte-count width and
// transfer op encoding, plus the latched transfer descriptor.
package bus_pkg;

  localparam int unsigned BC_W   = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RTAIL = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  typedef struct packed {
    op_t               op;
    logic [BC_W-1:0]   last;   // byte count minus one
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  // Keeps bytes 0..last of a little-endian word, zeroes the rest.
  function automatic logic [DATA_W-1:0] byte_mask(input logic [BC_W-1:0] last);
    return {DATA_W{1'b1}} >> {BC_W'(BC_W'(3) - last), 3'b000};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant advances only when the grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_c,
  output logic       valid_c
);

  logic last_grant;

  always_comb begin
    valid_c = |req;
    grant_c = 1'b0;
    if (req == 2'b11) grant_c = ~last_grant;
    else              grant_c = req[1];
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last_grant <= 1'b1;
    else if (accept) last_grant <= grant_c;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a byte-wide, latency-1 synchronous RAM between two cpu-bus requesters,
// splitting 1-4 byte requests into little-endian byte accesses.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_dataOut,
  input  logic [1:0]        m0_byteCount,
  output logic [31:0]       m0_dataIn,
  output logic              m0_dataInReady,
  output logic              m0_dataOutReady,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_dataOut,
  input  logic [1:0]        m1_byteCount,
  output logic [31:0]       m1_dataIn,
  output logic              m1_dataInReady,
  output logic              m1_dataOutReady,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state_q, state_d;
  logic [BC_W-1:0]   idx_q, idx_d;
  logic              owner_q, owner_d;
  xfer_t             xfer_q, xfer_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       asm_q, asm_d;

  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic [7:0]        mem_wdata_d;
  logic [31:0]       din0_d, din1_d;
  logic              rin0_d, rin1_d, rout0_d, rout1_d;

  logic              grant_c, valid_c, accept_c;
  logic [1:0]        req_c;
  logic              sel_write_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [31:0]       sel_wdata_c;
  logic [BC_W-1:0]   sel_last_c;
  logic [31:0]       final_c;

  assign req_c       = {m1_read | m1_write, m0_read | m0_write};
  assign sel_write_c = grant_c ? m1_write     : m0_write;
  assign sel_addr_c  = grant_c ? m1_address   : m0_address;
  assign sel_wdata_c = grant_c ? m1_dataOut   : m0_dataOut;
  assign sel_last_c  = grant_c ? m1_byteCount : m0_byteCount;

  // Read result once the final byte arrives from the RAM.
  assign final_c = (asm_q | (32'(mem_rdata) << {xfer_q.last, 3'b000}))
                   & byte_mask(xfer_q.last);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_c),
    .accept  (accept_c),
    .grant_c (grant_c),
    .valid_c (valid_c)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    owner_d     = owner_q;
    xfer_d      = xfer_q;
    base_d      = base_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata;
    din0_d      = m0_dataIn;
    din1_d      = m1_dataIn;
    rin0_d      = 1'b0;
    rin1_d      = 1'b0;
    rout0_d     = 1'b0;
    rout1_d     = 1'b0;
    accept_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_c) begin
          accept_c     = 1'b1;
          owner_d      = grant_c;
          xfer_d.op    = sel_write_c ? OP_WRITE : OP_READ;
          xfer_d.last  = sel_last_c;
          xfer_d.wdata = sel_wdata_c;
          base_d       = sel_addr_c;
          asm_d        = '0;
          idx_d        = '0;
          mem_addr_d   = sel_addr_c;
          mem_we_d     = sel_write_c;
          mem_wdata_d  = sel_wdata_c[7:0];
          state_d      = XFER;
        end
      end
      XFER: begin
        // RAM output now holds the byte addressed in the previous cycle.
        if (xfer_q.op == OP_READ && idx_q != '0)
          asm_d = asm_q | (32'(mem_rdata) << {BC_W'(idx_q - BC_W'(1)), 3'b000});
        if (idx_q == xfer_q.last) begin
          if (xfer_q.op == OP_WRITE) begin
            state_d = DONE;
            rout0_d = ~owner_q;
            rout1_d = owner_q;
          end else begin
            state_d = RTAIL;
          end
        end else begin
          idx_d       = idx_q + BC_W'(1);
          mem_addr_d  = base_q + ADDR_W'(idx_d);
          mem_we_d    = (xfer_q.op == OP_WRITE);
          mem_wdata_d = 8'(xfer_q.wdata >> {idx_d, 3'b000});
        end
      end
      RTAIL: begin
        state_d = DONE;
        if (owner_q) begin
          din1_d = final_c;
          rin1_d = 1'b1;
        end else begin
          din0_d = final_c;
          rin0_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      owner_q         <= 1'b0;
      xfer_q          <= '0;
      base_q          <= '0;
      asm_q           <= '0;
      mem_addr        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      m0_dataIn       <= '0;
      m1_dataIn       <= '0;
      m0_dataInReady  <= 1'b0;
      m1_dataInReady  <= 1'b0;
      m0_dataOutReady <= 1'b0;
      m1_dataOutReady <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      owner_q         <= owner_d;
      xfer_q          <= xfer_d;
      base_q          <= base_d;
      asm_q           <= asm_d;
      mem_addr        <= mem_addr_d;
      mem_we          <= mem_we_d;
      mem_wdata       <= mem_wdata_d;
      m0_dataIn       <= din0_d;
      m1_dataIn       <= din1_d;
      m0_dataInReady  <= rin0_d;
      m1_dataInReady  <= rin1_d;
      m0_dataOutReady <= rout0_d;
      m1_dataOutReady <= rout1_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: behavioural latency-1 RAM, expected
// completions queued at drive time and matched when a ready pulse appears.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_dataOut, m1_dataOut;
  logic [1:0]  m0_byteCount, m1_byteCount;
  logic [31:0] m0_dataIn, m1_dataIn;
  logic        m0_dataInReady, m0_dataOutReady, m1_dataInReady, m1_dataOutReady;
  logic [23:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ram [logic [23:0]];
  logic [31:0] exp_din [2];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(24)) dut (
    .clk             (clk),
    .rst             (rst),
    .m0_address      (m0_address),
    .m0_read         (m0_read),
    .m0_write        (m0_write),
    .m0_dataOut      (m0_dataOut),
    .m0_byteCount    (m0_byteCount),
    .m0_dataIn       (m0_dataIn),
    .m0_dataInReady  (m0_dataInReady),
    .m0_dataOutReady (m0_dataOutReady),
    .m1_address      (m1_address),
    .m1_read         (m1_read),
    .m1_write        (m1_write),
    .m1_dataOut      (m1_dataOut),
    .m1_byteCount    (m1_byteCount),
    .m1_dataIn       (m1_dataIn),
    .m1_dataInReady  (m1_dataInReady),
    .m1_dataOutReady (m1_dataOutReady),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata)
  );

  function automatic logic [7:0] ram_rd(input logic [23:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= ram_rd(mem_addr);
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic        ri, ro;
    logic [31:0] d;
    exp_t        e;
    if (rst === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        ri = (p == 0) ? m0_dataInReady  : m1_dataInReady;
        ro = (p == 0) ? m0_dataOutReady : m1_dataOutReady;
        d  = (p == 0) ? m0_dataIn       : m1_dataIn;
        if (ri || ro) begin
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("grant_port", 32'(p), 32'(e.port));
            check("ready_kind", {30'd0, ri, ro}, e.rd ? 32'd2 : 32'd1);
            if (e.rd) check("read_data", d, e.data);
          end
        end
      end
    end
  end

  task automatic drive(input int p, input bit rd, input bit wr, input logic [23:0] a,
                       input logic [1:0] bc, input logic [31:0] wd);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteCount = bc; m0_dataOut = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteCount = bc; m1_dataOut = wd;
    end
  endtask

  // One transaction on one port, called and returning at a falling edge.
  task automatic do_txn(input int p, input bit rd, input bit wr, input logic [23:0] a,
                        input logic [1:0] bc, input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    int   lat, cnt;
    bit   seen;
    e.port = p; e.rd = !wr; e.data = exp_rd;
    sb.push_back(e);
    lat = wr ? int'(bc) + 2 : int'(bc) + 3;
    drive(p, rd, wr, a, bc, wd);
    cnt = 0; seen = 0;
    while (!seen && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      seen = (p == 0) ? (m0_dataInReady | m0_dataOutReady) : (m1_dataInReady | m1_dataOutReady);
    end
    check("latency", 32'(cnt), 32'(lat));
    drive(p, 1'b0, 1'b0, '0, '0, '0);
    if (!wr) exp_din[p] = exp_rd;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n, cyc;
    rst = 1'b0;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    exp_din[0] = '0; exp_din[1] = '0;
    ram[24'h000100] = 8'hAB;
    ram[24'hFFFFFF] = 8'h34;
    ram[24'h000000] = 8'h12;
    #2;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_readys", {28'd0, m0_dataInReady, m0_dataOutReady, m1_dataInReady, m1_dataOutReady}, 32'd0);
    check("rst_m0_din", m0_dataIn, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_txn(0, 1, 0, 24'h000100, 2'd0, 32'h0, 32'h0000_00AB);
    check("m1_din_hold", m1_dataIn, exp_din[1]);

    do_txn(1, 0, 1, 24'h000200, 2'd3, 32'h1122_3344, 32'h0);
    check("ram_200", 32'(ram_rd(24'h000200)), 32'h44);
    check("ram_201", 32'(ram_rd(24'h000201)), 32'h33);
    check("ram_202", 32'(ram_rd(24'h000202)), 32'h22);
    check("ram_203", 32'(ram_rd(24'h000203)), 32'h11);
    do_txn(0, 1, 0, 24'h000200, 2'd3, 32'h0, 32'h1122_3344);
    do_txn(1, 1, 0, 24'h000200, 2'd2, 32'h0, 32'h0022_3344);
    check("m0_din_hold", m0_dataIn, exp_din[0]);

    do_txn(0, 1, 0, 24'hFFFFFF, 2'd1, 32'h0, 32'h0000_1234);

    // Read and write together: write wins, read data untouched.
    do_txn(0, 1, 1, 24'h000400, 2'd1, 32'h0000_BEEF, 32'h0);
    check("ram_400", 32'(ram_rd(24'h000400)), 32'hEF);
    check("ram_401", 32'(ram_rd(24'h000401)), 32'hBE);
    check("rw_m0_din", m0_dataIn, exp_din[0]);

    // Reset during byte 2 of a dword write.
    drive(0, 0, 1, 24'h000300, 2'd3, 32'hA1B2_C3D4);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_ready", 32'(m0_dataOutReady), 32'd0);
    drive(0, 0, 0, '0, '0, '0);
    exp_din[0] = '0; exp_din[1] = '0;
    repeat (2) @(negedge clk);
    check("abort_ram_300", 32'(ram_rd(24'h000300)), 32'hD4);
    check("abort_ram_301", 32'(ram_rd(24'h000301)), 32'hC3);
    check("abort_ram_302", 32'(ram_rd(24'h000302)), 32'h00);
    check("abort_m0_din", m0_dataIn, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Both ports held: grants alternate, port 0 first after reset.
    for (int k = 0; k < 4; k++) begin
      e.port = k % 2;
      e.rd   = 1'b1;
      e.data = (k % 2 == 0) ? 32'h0000_00AB : 32'h1122_3344;
      sb.push_back(e);
    end
    drive(0, 1, 0, 24'h000100, 2'd0, 32'h0);
    drive(1, 1, 0, 24'h000200, 2'd3, 32'h0);
    n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m0_dataInReady || m1_dataInReady) n++;
    end
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    check("tie_count", 32'(n), 32'd4);
    repeat (3) @(negedge clk);
    check("tie_m0_din", m0_dataIn, 32'h0000_00AB);
    check("tie_m1_din", m1_dataIn, 32'h1122_3344);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
